// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the input_control button path.
// FSM encoding and timing defaults used by the debouncer.
package input_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

  localparam int STABLE_CNT_DEF = 4;
  localparam int CNT_W_DEF      = 3;
  localparam int TICK_DIV       = 100;

endpackage

// File: rtl/input_debouncer_if.sv
// Button bundle between input_control and the debouncer.
// Master drives sample clock and raw buttons; slave returns clean levels.
interface input_debouncer_if #(
  parameter int N_BTN = 4
) ();

  logic             clk100;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             tick;

  modport master (
    output clk100,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  tick
  );

  modport slave (
    input  clk100,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output tick
  );

endinterface

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchroniser, stability FSM and
// registered level / press / release outputs.
module debounce_cell
  import input_ctrl_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0] sync_q;
  logic       sync;
  db_state_t  state;
  logic [CNT_W-1:0] cnt;

  assign sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // cnt holds the number of ticks the new value has already been seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        unique case (state)
          S_LOW: begin
            if (sync) begin
              state <= S_RISE;
              cnt   <= ONE;
            end else begin
              cnt   <= '0;
            end
          end
          S_RISE: begin
            if (!sync) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= S_HIGH;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt   <= cnt + ONE;
            end
          end
          S_HIGH: begin
            if (!sync) begin
              state <= S_FALL;
              cnt   <= ONE;
            end else begin
              cnt   <= '0;
            end
          end
          S_FALL: begin
            if (sync) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= S_LOW;
              cnt   <= '0;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              cnt   <= cnt + ONE;
            end
          end
          default: begin
            state <= S_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debouncer top: edge-detects clk100 into a one-cycle sample tick
// and fans it out to one debounce_cell per button.
module input_debouncer
  import input_ctrl_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input_debouncer_if.slave  bus
);

  logic clk100_q;
  logic tick_q;

  // clk100_q resets high so a high clk100 at release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk100_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      clk100_q <= bus.clk100;
      tick_q   <= bus.clk100 & ~clk100_q;
    end
  end

  assign bus.tick = tick_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_q),
      .raw   (bus.btn_raw[i]),
      .level (bus.btn_level[i]),
      .press (bus.btn_press[i]),
      .rel   (bus.btn_release[i])
    );
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Sits directly downstream of freqdiv100 in input_control.
- Consumes its divided clock output (clk100) as a sample-enable, not as a clock.
- Synchronises N raw push-button inputs into the clk domain and debounces each one.
- Produces clean levels plus one-cycle press/release pulses for the control logic further downstream.

Parameters:
- N_BTN, 4, number of independent button channels.
- STABLE_CNT, 4, number of consecutive sample ticks with identical value required to accept a new level. Legal range 2..(2^CNT_W - 1).
- CNT_W, 3, width of each per-channel stability counter.

Ports:
- clk  input  1  system clock; same clock that drives freqdiv100.
- rst_n  input  1  asynchronous, active-low reset.
- clk100  input  1  divided clock from freqdiv100, generated from clk; treated as synchronous data.
- btn_raw  input  N_BTN  raw, bouncy, asynchronous button inputs; 1 = pressed.
- btn_level  output  N_BTN  debounced button level, registered.
- btn_press  output  N_BTN  one-clk pulse on an accepted 0->1 transition, registered.
- btn_release  output  N_BTN  one-clk pulse on an accepted 1->0 transition, registered.
- tick  output  1  registered sample strobe, exported for debug and verification.

Behaviour:
- Reset (async assert, sync release to clk):
  - btn_level, btn_press, btn_release, tick = 0.
  - Synchroniser flops = 0.
  - All channel FSMs in S_LOW, all counters 0.
  - clk100_q resets to 1, so clk100 already high at reset release produces no spurious tick.
- Tick generation:
  - clk100_q <= clk100 every clk.
  - tick <= clk100 & ~clk100_q.
  - tick is high for exactly one clk per clk100 rising edge, 1 clk after that edge is seen.
- Synchroniser:
  - Two flops per bit on btn_raw, updated every clk.
  - sync[i] = second flop output.
- Per-channel FSM:
  - States: S_LOW, S_RISE, S_HIGH, S_FALL.
  - State and counter update only in cycles where tick=1; otherwise everything holds.
  - S_LOW: sync=1 -> S_RISE, cnt=1. sync=0 -> stay, cnt=0.
  - S_RISE: sync=1 and cnt+1==STABLE_CNT -> S_HIGH, cnt=0, btn_level<=1, btn_press<=1. sync=1 otherwise -> cnt+1. sync=0 -> S_LOW, cnt=0.
  - S_HIGH: mirror of S_LOW; sync=0 -> S_FALL, cnt=1.
  - S_FALL: sync=0 and cnt+1==STABLE_CNT -> S_LOW, btn_level<=0, btn_release<=1. sync=1 -> S_HIGH, cnt=0.
  - btn_press and btn_release auto-clear the following clk; a pulse is never longer than 1 cycle.
  - press and release are never high simultaneously on the same channel.
- Latency:
  - A clean edge on btn_raw reaches btn_level after 2 clk (synchroniser) + STABLE_CNT ticks + 1 clk.
  - With a 100-clk tick period: at most 2 + 100*STABLE_CNT + 1 clk.
- Glitch rejection:
  - Any excursion not seen on STABLE_CNT consecutive ticks is discarded.
  - Excursions falling entirely between two ticks are invisible.
- Channels are fully independent; simultaneous transitions on several channels each pulse in the same cycle.
- Counters never wrap, because the terminal value triggers the state change.
- clk100 stuck at 0 or 1: no ticks, all outputs hold their current values.
- Reset asserted mid-S_RISE or mid-S_FALL: immediate return to reset values; no pulse is emitted.

Decomposition:
- Shared package input_ctrl_pkg holds:
  - FSM state encoding (2 bits: S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3).
  - Default STABLE_CNT.
  - Tick period constant TICK_DIV=100, matching freqdiv100.
- Sub-module debounce_cell:
  - Contains synchroniser, FSM, counter and the three outputs for one bit.
  - Instantiated N_BTN times via generate.
- Top level holds only tick generation and the generate loop.

Test Plan:
- Reset release with clk100 already high -> tick stays 0 until the next clk100 rising edge; all outputs 0.
- btn_raw[0]=1 held for 600 clk (ticks every 100 clk) -> exactly one btn_press[0] pulse of 1 clk. btn_level[0]=1 within 403 clk of the edge. Other channels stay 0.
- btn_raw[1] toggling every 30 clk for 300 clk, then steady 1 -> no press during bouncing. Exactly one press 4 ticks after it settles.
- btn_level[2]=1, then a 0-pulse of 150 clk spanning 1-2 ticks -> no release; level remains 1; FSM returns to S_HIGH.
- btn_raw[3:0]=4'b1111 applied together, later 4'b0000 -> btn_press=4'b1111 in one cycle, later btn_release=4'b1111 in one cycle.
- rst_n pulsed low after 2 accepted ticks in S_RISE -> outputs 0 immediately. The count restarts from 0 after release; press occurs only after 4 fresh ticks.
